// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a single-entry valid/ready holding register.
// Define SIPO_MSB_FIRST_EN to place the first chunk in the MSB slice (I2C wire order).
module sipo_deserializer #(
  parameter int SIZE_DATA_IN  = 1,
  parameter int SIZE_DATA_OUT = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  input  logic                     i_clear,
  input  logic                     i_ready,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_overrun
);

  localparam int DEPTH = SIZE_DATA_OUT / SIZE_DATA_IN;
  localparam int CW    = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  generate
    if (DEPTH < 2 || DEPTH * SIZE_DATA_IN != SIZE_DATA_OUT) begin : g_bad_cfg
      $error("sipo_deserializer: SIZE_DATA_OUT must be >=2 whole multiples of SIZE_DATA_IN");
    end
  endgenerate

  typedef enum logic {F_IDLE, F_FILL} fill_t;
  typedef enum logic {H_EMPTY, H_FULL} hold_t;

  fill_t fill_q, fill_d;
  hold_t hold_q, hold_d;

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            slot;
  logic [SIZE_DATA_OUT-1:0] asm_q, asm_d;
  logic [SIZE_DATA_OUT-1:0] data_q, data_d;
  logic                     ovr_q, ovr_d;
  logic                     accept;
  logic                     complete;
  logic                     load;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fill_q <= F_IDLE;
      hold_q <= H_EMPTY;
      cnt_q  <= '0;
      asm_q  <= '0;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      data_q <= data_d;
      ovr_q  <= ovr_d;
    end
  end

  // Clear wins over a same-cycle chunk; the completing chunk merges combinationally.
  always_comb begin
    accept   = i_valid & ~i_clear;
    complete = accept & (cnt_q == LAST);
`ifdef SIPO_MSB_FIRST_EN
    slot = LAST - cnt_q;
`else
    slot = cnt_q;
`endif
    asm_d = asm_q;
    for (int s = 0; s < DEPTH; s++) begin
      if (accept && slot == CW'(s)) begin
        asm_d[s*SIZE_DATA_IN +: SIZE_DATA_IN] = i_data;
      end
    end

    cnt_d = cnt_q;
    if (i_clear)       cnt_d = '0;
    else if (complete) cnt_d = '0;
    else if (accept)   cnt_d = cnt_q + 1'b1;

    fill_d = fill_q;
    unique case (fill_q)
      F_IDLE: if (accept && !complete) fill_d = F_FILL;
      F_FILL: if (i_clear || complete) fill_d = F_IDLE;
      default: fill_d = F_IDLE;
    endcase

    load   = complete & ((hold_q == H_EMPTY) | i_ready);
    ovr_d  = complete & (hold_q == H_FULL) & ~i_ready;
    data_d = data_q;
    hold_d = hold_q;
    unique case (hold_q)
      H_EMPTY: if (complete) hold_d = H_FULL;
      H_FULL:  if (i_ready && !complete) hold_d = H_EMPTY;
      default: hold_d = H_EMPTY;
    endcase
    if (load) data_d = asm_d;
    else if (hold_q == H_FULL && i_ready) data_d = '0;
  end

  always_comb begin
    o_valid   = (hold_q == H_FULL);
    o_data    = o_valid ? data_q : '0;
    o_busy    = (fill_q == F_FILL);
    o_overrun = ovr_q;
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (1-bit and 2-bit chunk builds).
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, clear, ready;
  logic [0:0] data;
  logic [7:0] odata;
  logic       ovalid, obusy, oovr;

  logic       valid2, clear2, ready2;
  logic [1:0] data2;
  logic [7:0] odata2;
  logic       ovalid2, obusy2, oovr2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.SIZE_DATA_IN(1), .SIZE_DATA_OUT(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
    .i_clear(clear), .i_ready(ready), .o_data(odata),
    .o_valid(ovalid), .o_busy(obusy), .o_overrun(oovr)
  );

  sipo_deserializer #(.SIZE_DATA_IN(2), .SIZE_DATA_OUT(8)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid2), .i_data(data2),
    .i_clear(clear2), .i_ready(ready2), .o_data(odata2),
    .o_valid(ovalid2), .o_busy(obusy2), .o_overrun(oovr2)
  );

`ifdef SIPO_MSB_FIRST_EN
  localparam logic [7:0] EXP_T1 = 8'hB2;
  localparam logic [7:0] EXP_T2 = 8'h6C;
`else
  localparam logic [7:0] EXP_T1 = 8'h4D;
  localparam logic [7:0] EXP_T2 = 8'h39;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    valid = 1'b1;
    data  = b;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Sends bits in whichever order rebuilds v in the current build.
  task automatic send_byte(input logic [7:0] v, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && rdy_last) ready = 1'b1;
`ifdef SIPO_MSB_FIRST_EN
      send_bit(v[7-i]);
`else
      send_bit(v[i]);
`endif
    end
  endtask

  task automatic send2(input logic [1:0] c);
    valid2 = 1'b1;
    data2  = c;
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  initial begin
    logic [7:0] t1bits;
    rst = 1'b1; valid = 0; clear = 0; ready = 1; data = '0;
    valid2 = 0; clear2 = 0; ready2 = 1; data2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {7'd0, ovalid}, 8'd0);
    chk("rst_data", odata, 8'd0);
    chk("rst_busy", {7'd0, obusy}, 8'd0);
    chk("rst_ovr", {7'd0, oovr}, 8'd0);

    // bits 1,0,1,1,0,0,1,0 in wire order
    t1bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      send_bit(t1bits[i]);
      if (i == 0) begin
        chk("t1_busy_first", {7'd0, obusy}, 8'd1);
        chk("t1_novalid", {7'd0, ovalid}, 8'd0);
      end
    end
    chk("t1_valid", {7'd0, ovalid}, 8'd1);
    chk("t1_data", odata, EXP_T1);
    chk("t1_busy_done", {7'd0, obusy}, 8'd0);
    @(negedge clk);
    chk("t1_drained", {7'd0, ovalid}, 8'd0);
    chk("t1_data_zero", odata, 8'd0);

    send2(2'b01);
    chk("t2_busy", {7'd0, obusy2}, 8'd1);
    send2(2'b10);
    send2(2'b11);
    send2(2'b00);
    chk("t2_valid", {7'd0, ovalid2}, 8'd1);
    chk("t2_data", odata2, EXP_T2);
    chk("t2_busy_done", {7'd0, obusy2}, 8'd0);
    @(negedge clk);

    ready = 1'b0;
    send_byte(8'h4D, 1'b0);
    chk("t3_valid", {7'd0, ovalid}, 8'd1);
    chk("t3_data", odata, 8'h4D);
    chk("t3_no_ovr", {7'd0, oovr}, 8'd0);
    send_byte(8'hFF, 1'b0);
    chk("t3_ovr", {7'd0, oovr}, 8'd1);
    chk("t3_held", odata, 8'h4D);
    @(negedge clk);
    chk("t3_ovr_pulse", {7'd0, oovr}, 8'd0);
    chk("t3_still", odata, 8'h4D);
    ready = 1'b1;
    @(negedge clk);
    chk("t3_drop", {7'd0, ovalid}, 8'd0);

    ready = 1'b0;
    send_byte(8'h4D, 1'b0);
    chk("t4_full", odata, 8'h4D);
    send_byte(8'hA5, 1'b1);
    chk("t4_valid", {7'd0, ovalid}, 8'd1);
    chk("t4_data", odata, 8'hA5);
    chk("t4_no_ovr", {7'd0, oovr}, 8'd0);
    @(negedge clk);
    chk("t4_drain", {7'd0, ovalid}, 8'd0);

    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    clear = 1'b1;
    send_bit(1'b0);
    clear = 1'b0;
    chk("t5_busy_clr", {7'd0, obusy}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      if (i == 3) chk("t5_no_early", {7'd0, ovalid}, 8'd0);
    end
    chk("t5_valid", {7'd0, ovalid}, 8'd1);
    chk("t5_data", odata, 8'hFF);
    @(negedge clk);
    chk("t5_single", {7'd0, ovalid}, 8'd0);

    ready = 1'b0;
    send_byte(8'h11, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("t6_pre_busy", {7'd0, obusy}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_valid", {7'd0, ovalid}, 8'd0);
    chk("t6_rst_data", odata, 8'd0);
    chk("t6_rst_busy", {7'd0, obusy}, 8'd0);
    chk("t6_rst_ovr", {7'd0, oovr}, 8'd0);
    ready = 1'b1;
    send_byte(8'h3C, 1'b0);
    chk("t6_valid", {7'd0, ovalid}, 8'd1);
    chk("t6_data", odata, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out deserializer: the receive-side counterpart of the controller's PISO serializer. It accumulates `SIZE_DATA_OUT/SIZE_DATA_IN` strobed input chunks into one word and presents that word on a valid/ready output with a single-entry holding register. In the I2C IP it sits between the SDA bit sampler and the RX byte path/register file. It also serves as the loopback checker for the PISO in block-level benches.

## Interface
Parameters:
- `SIZE_DATA_IN`, default 1: width of one input chunk.
- `SIZE_DATA_OUT`, default 8: width of the assembled word.
- `DEPTH`: derived, `SIZE_DATA_OUT/SIZE_DATA_IN`, chunks per word. Must divide exactly and be ≥ 2; elaboration-time assertion.

Ports:
- `i_clk` in 1: sole clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: one chunk present on `i_data` this cycle.
- `i_data` in `SIZE_DATA_IN`: input chunk.
- `i_clear` in 1: abort the partially assembled word (e.g. START/STOP detected mid-byte).
- `i_ready` in 1: downstream accepts `o_data` this cycle.
- `o_data` out `SIZE_DATA_OUT`: held word; forced to 0 while `o_valid`=0.
- `o_valid` out 1: holding register full.
- `o_busy` out 1: partial word in progress (chunk count ≠ 0).
- `o_overrun` out 1: one-cycle pulse when a completed word is dropped.

## Operation
- Assembly register `asm` (`SIZE_DATA_OUT`) and chunk counter `cnt` (`$clog2(DEPTH)` bits).
- Fill FSM states:
  - IDLE (`cnt`=0).
  - FILL (0<`cnt`<DEPTH).
  - Transitions: IDLE→FILL on `i_valid`; FILL→IDLE on the DEPTH-th `i_valid` or on `i_clear`.
- On an accepted chunk, `asm[cnt*SIZE_DATA_IN +: SIZE_DATA_IN] <= i_data` and `cnt` increments. Default order: the first chunk lands in the LSB slice.
- Completion: `i_valid` while `cnt`==DEPTH-1. The word is `{i_data, asm[...]}` merged combinationally, so no bubble occurs. `cnt` wraps to 0.
- Holding register has two states:
  - EMPTY→FULL on completion.
  - FULL→EMPTY when `o_valid & i_ready` and no completion that cycle.
- Completion while FULL with `i_ready`=1: the old word drains and the new word loads in the same cycle. `o_valid` stays 1 and there is no overrun.
- Completion while FULL with `i_ready`=0: the new word is discarded, the held word is unchanged, and `o_overrun`=1 for one cycle.
- `i_clear` has priority over `i_valid` in the same cycle: the chunk is ignored and `cnt`→0. `asm` contents are don't-care. The holding register is untouched.
- `asm` is not cleared between words. Only slots written in the current word are used.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_busy`=0, `o_overrun`=0, `cnt`=0, holding register EMPTY.
- Reset mid-word or with FULL holding discards everything. Outputs take their reset values on the edge after `i_rst`=1 is sampled.
- Latency: completing chunk sampled at edge N → `o_valid`=1 and word on `o_data` after edge N (visible in cycle N+1).
- `o_busy` is registered: it rises the cycle after the first chunk and falls the cycle after completion or clear.
- `o_overrun` is registered, asserted in the cycle after the dropped completion.
- Back-to-back `i_valid` every cycle is supported: one word every DEPTH cycles, sustained with `i_ready`=1.
- `i_ready` while `o_valid`=0 is ignored.
- `o_data` is stable while `o_valid`=1 and `i_ready`=0.

## Configuration
- `SIPO_MSB_FIRST_EN`:
  - Defined: the first chunk lands in the MSB slice, `asm[(DEPTH-1-cnt)*SIZE_DATA_IN +: SIZE_DATA_IN]`. This matches I2C wire order.
  - Undefined: LSB-first as above, which matches the PISO output order for loopback.
- Timing, handshake and counters are identical in both builds.

## Test plan
- IN=1, OUT=8, `i_ready`=1; bits 1,0,1,1,0,0,1,0 on consecutive cycles:
  - Undefined: `o_valid` one cycle after the 8th bit, `o_data`=0x4D.
  - With `SIPO_MSB_FIRST_EN`: `o_data`=0xB2.
- IN=2, OUT=8; chunks 01,10,11,00 → `o_data`=0x39 (LSB-first). `o_busy`=1 after chunk 1 and 0 after completion.
- `i_ready`=0; send 0x4D then 0xFF (16 bits) → `o_overrun` pulses once, `o_data` stays 0x4D. After `i_ready`=1, `o_valid` drops.
- Holding FULL (0x4D), `i_ready`=1 on the exact completion cycle of 0xA5 → no overrun, next `o_data`=0xA5, `o_valid` continuous.
- 3 bits, then `i_clear` together with `i_valid`, then eight 1-bits → single output 0xFF, no stale bits.
- Reset after 5 bits with a word held → all outputs 0. The next 8 bits of 0x3C yield exactly 0x3C.
